// File: rtl/aclock_set_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// aclock_set_ctrl
//
// Button-driven setting/sequencing controller for the aclock alarm-clock core.
// Turns four debounced single-cycle button pulses into BCD digit buses plus
// held LD_time / LD_alarm / STOP_al strobes, and owns the AL_ON enable level.
// Sits between the front-panel debouncers and aclock; reads aclock's current
// time outputs to preload a time edit.
//
// Optional feature macro: ACLOCK_SNOOZE_EN
//   defined   : btn_inc in IDLE while the alarm rings with AL_ON=1 snoozes
//               (STOP_al burst, shadow += SNOOZE_MIN, LD_alarm burst).
//   undefined : btn_inc in IDLE always toggles AL_ON.
//
// Parameters
//   LD_HOLD      cycles each LD_time / LD_alarm / STOP_al strobe is held (>=1)
//   TIMEOUT_CYC  idle cycles in an edit state before the edit is abandoned
//   SNOOZE_MIN   minutes added to the alarm on snooze (1..59)
//
// Ports
//   clk                      system clock, rising edge
//   reset                    asynchronous, active-low reset
//   btn_mode/set/inc/stop    single-cycle button pulses
//   Alarm                    alarm-ringing flag from aclock
//   H_out1/H_out0/M_out1/M_out0  current time from aclock (BCD)
//   H_in1/H_in0/M_in1/M_in0  edit value to aclock (BCD, registered)
//   LD_time/LD_alarm/STOP_al held strobes to aclock, mutually exclusive
//   AL_ON                    alarm enable level
//   edit_st                  00 idle, 01 hour field, 10 minute field, 11 busy
// -----------------------------------------------------------------------------
module aclock_set_ctrl #(
    parameter int LD_HOLD     = 10,
    parameter int TIMEOUT_CYC = 300,
    parameter int SNOOZE_MIN  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_set,
    input  logic       btn_inc,
    input  logic       btn_stop,
    input  logic       Alarm,
    input  logic [1:0] H_out1,
    input  logic [3:0] H_out0,
    input  logic [3:0] M_out1,
    input  logic [3:0] M_out0,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       STOP_al,
    output logic       AL_ON,
    output logic [1:0] edit_st
);

    // Elaboration-time sanity checks on the configuration.
    if (LD_HOLD < 1) begin : g_bad_hold
        $error("aclock_set_ctrl: LD_HOLD must be >= 1");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("aclock_set_ctrl: TIMEOUT_CYC must be >= 1");
    end
    if (SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_bad_snooze
        $error("aclock_set_ctrl: SNOOZE_MIN must be 1..59");
    end

    localparam int HOLD_W  = $clog2(LD_HOLD + 1);
    localparam int QUIET_W = $clog2(TIMEOUT_CYC + 1);

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } hhmm_t;

`ifdef ACLOCK_SNOOZE_EN
    typedef enum logic [2:0] {
        S_IDLE, S_HR, S_MIN, S_LOAD, S_STOP, S_SNZ_STOP, S_SNZ_LOAD
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_HR, S_MIN, S_LOAD, S_STOP
    } state_t;
`endif

    // BCD hour increment, 23 wraps to 00.
    function automatic hhmm_t hour_inc(hhmm_t t);
        hhmm_t r;
        r = t;
        if (t.h1 == 2'd2 && t.h0 == 4'd3) begin
            r.h1 = 2'd0;
            r.h0 = 4'd0;
        end else if (t.h0 == 4'd9) begin
            r.h1 = t.h1 + 2'd1;
            r.h0 = 4'd0;
        end else begin
            r.h0 = t.h0 + 4'd1;
        end
        return r;
    endfunction

    // BCD minute increment, 59 wraps to 00 without touching the hour.
    function automatic hhmm_t min_inc(hhmm_t t);
        hhmm_t r;
        r = t;
        if (t.m0 == 4'd9) begin
            r.m0 = 4'd0;
            r.m1 = (t.m1 == 4'd5) ? 4'd0 : t.m1 + 4'd1;
        end else begin
            r.m0 = t.m0 + 4'd1;
        end
        return r;
    endfunction

`ifdef ACLOCK_SNOOZE_EN
    // Add SNOOZE_MIN minutes with carry into the hour; 23:5x wraps to 00:0x.
    function automatic hhmm_t snooze_add(hhmm_t t);
        logic [6:0] mins;
        logic [4:0] hrs;
        hhmm_t      r;
        mins = 7'(t.m1) * 7'd10 + 7'(t.m0) + 7'(SNOOZE_MIN);
        hrs  = 5'(t.h1) * 5'd10 + 5'(t.h0);
        if (mins >= 7'd60) begin
            mins = mins - 7'd60;
            hrs  = (hrs == 5'd23) ? 5'd0 : hrs + 5'd1;
        end
        r.h1 = 2'(hrs / 5'd10);
        r.h0 = 4'(hrs % 5'd10);
        r.m1 = 4'(mins / 7'd10);
        r.m0 = 4'(mins % 7'd10);
        return r;
    endfunction
`endif

    state_t              state_q, state_d;
    logic                tgt_alarm_q, tgt_alarm_d;   // 0: editing time, 1: editing alarm
    hhmm_t               edit_q, edit_d;
    hhmm_t               shadow_q, shadow_d;         // last committed alarm value
    logic                al_on_q, al_on_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;             // strobe hold counter
    logic [QUIET_W-1:0]  quiet_q, quiet_d;           // idle cycles inside an edit

    // Coincident presses resolve as stop > mode > set > inc; only the winner acts.
    logic press_stop, press_mode, press_set, press_inc;
    assign press_stop = btn_stop;
    assign press_mode = btn_mode & ~btn_stop;
    assign press_set  = btn_set  & ~btn_stop & ~btn_mode;
    assign press_inc  = btn_inc  & ~btn_stop & ~btn_mode & ~btn_set;

    logic hold_done;
    assign hold_done = (hold_q == HOLD_W'(LD_HOLD - 1));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            tgt_alarm_q <= 1'b0;
            edit_q      <= '0;
            shadow_q    <= '0;
            al_on_q     <= 1'b0;
            hold_q      <= '0;
            quiet_q     <= '0;
        end else begin
            state_q     <= state_d;
            tgt_alarm_q <= tgt_alarm_d;
            edit_q      <= edit_d;
            shadow_q    <= shadow_d;
            al_on_q     <= al_on_d;
            hold_q      <= hold_d;
            quiet_q     <= quiet_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case, so no path through
        // the block leaves a value unassigned and no latch is inferred.
        state_d     = state_q;
        tgt_alarm_d = tgt_alarm_q;
        edit_d      = edit_q;
        shadow_d    = shadow_q;
        al_on_d     = al_on_q;
        hold_d      = hold_q;
        quiet_d     = quiet_q;
        LD_time     = 1'b0;
        LD_alarm    = 1'b0;
        STOP_al     = 1'b0;
        edit_st     = 2'b11;

        unique case (state_q)
            S_IDLE: begin
                edit_st = 2'b00;
                hold_d  = '0;
                quiet_d = '0;
                if (press_stop) begin
                    if (Alarm) state_d = S_STOP;
                end else if (press_mode) begin
                    state_d     = S_HR;
                    tgt_alarm_d = 1'b0;
                    edit_d      = '{h1: H_out1, h0: H_out0, m1: M_out1, m0: M_out0};
                end else if (press_set) begin
                    state_d     = S_HR;
                    tgt_alarm_d = 1'b1;
                    edit_d      = shadow_q;
                end else if (press_inc) begin
`ifdef ACLOCK_SNOOZE_EN
                    if (Alarm && al_on_q) state_d = S_SNZ_STOP;
                    else                  al_on_d = ~al_on_q;
`else
                    al_on_d = ~al_on_q;
`endif
                end
            end

            S_HR, S_MIN: begin
                edit_st = (state_q == S_HR) ? 2'b01 : 2'b10;
                if (press_stop) begin
                    state_d = S_IDLE;
                end else if (press_mode) begin
                    quiet_d = '0;
                    if (state_q == S_HR) begin
                        state_d = S_MIN;
                    end else begin
                        state_d = S_LOAD;
                        hold_d  = '0;
                        if (tgt_alarm_q) shadow_d = edit_q;
                    end
                end else if (press_inc) begin
                    quiet_d = '0;
                    edit_d  = (state_q == S_HR) ? hour_inc(edit_q) : min_inc(edit_q);
                end else if (quiet_q == QUIET_W'(TIMEOUT_CYC - 1)) begin
                    // Abandon the edit: nothing is loaded and the shadow stays put.
                    state_d = S_IDLE;
                end else begin
                    quiet_d = quiet_q + 1'b1;
                end
            end

            S_LOAD: begin
                LD_time  = ~tgt_alarm_q;
                LD_alarm = tgt_alarm_q;
                if (hold_done) state_d = S_IDLE;
                else           hold_d  = hold_q + 1'b1;
            end

            S_STOP: begin
                STOP_al = 1'b1;
                if (hold_done) state_d = S_IDLE;
                else           hold_d  = hold_q + 1'b1;
            end

`ifdef ACLOCK_SNOOZE_EN
            S_SNZ_STOP: begin
                STOP_al = 1'b1;
                if (hold_done) begin
                    // Advance the alarm and present it on the edit bus for the load burst.
                    state_d  = S_SNZ_LOAD;
                    hold_d   = '0;
                    shadow_d = snooze_add(shadow_q);
                    edit_d   = snooze_add(shadow_q);
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            S_SNZ_LOAD: begin
                LD_alarm = 1'b1;
                if (hold_done) state_d = S_IDLE;
                else           hold_d  = hold_q + 1'b1;
            end
`endif

            default: state_d = S_IDLE;
        endcase
    end

    assign H_in1 = edit_q.h1;
    assign H_in0 = edit_q.h0;
    assign M_in1 = edit_q.m1;
    assign M_in0 = edit_q.m0;
    assign AL_ON = al_on_q;

endmodule

// File: tb/tb_aclock_set_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for aclock_set_ctrl: a clock-time level model (integer
// hours/minutes plus a queue of pending strobe cycles) is compared against the
// DUT on every falling edge, and directed scenarios add literal expectations.
module tb_aclock_set_ctrl;

    localparam int LD_HOLD     = 10;
    localparam int TIMEOUT_CYC = 300;
    localparam int SNOOZE_MIN  = 5;
`ifdef ACLOCK_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif

    logic       clk, reset;
    logic       btn_mode, btn_set, btn_inc, btn_stop, Alarm;
    logic [1:0] H_out1;
    logic [3:0] H_out0, M_out1, M_out0;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm, STOP_al, AL_ON;
    logic [1:0] edit_st;

    aclock_set_ctrl #(
        .LD_HOLD(LD_HOLD), .TIMEOUT_CYC(TIMEOUT_CYC), .SNOOZE_MIN(SNOOZE_MIN)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_set(btn_set), .btn_inc(btn_inc), .btn_stop(btn_stop),
        .Alarm(Alarm),
        .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .STOP_al(STOP_al),
        .AL_ON(AL_ON), .edit_st(edit_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int K_NONE = 0, K_TIME = 1, K_ALARM = 2, K_STOP = 3;
    typedef struct { int kind; int h; int m; } ent_t;

    ent_t q[$];          // one entry per busy cycle still to come
    int   mode;          // 0 idle, 1 hour field, 2 minute field (when not busy)
    int   m_hour, m_min; // value on the edit bus
    int   s_hour, s_min; // committed alarm
    bit   alon, tgt_alarm;
    int   quiet;
    bit   cmp_en = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            mode = 0; m_hour = 0; m_min = 0; s_hour = 0; s_min = 0;
            alon = 0; tgt_alarm = 0; quiet = 0; q.delete();
        end else if (q.size() != 0) begin
            void'(q.pop_front());
            if (q.size() != 0) begin
                m_hour = q[0].h;
                m_min  = q[0].m;
            end
        end else if (mode == 0) begin
            if (btn_stop) begin
                if (Alarm) for (int i = 0; i < LD_HOLD; i++) q.push_back('{K_STOP, m_hour, m_min});
            end else if (btn_mode) begin
                mode = 1; tgt_alarm = 0; quiet = 0;
                m_hour = int'(H_out1) * 10 + int'(H_out0);
                m_min  = int'(M_out1) * 10 + int'(M_out0);
            end else if (btn_set) begin
                mode = 1; tgt_alarm = 1; quiet = 0;
                m_hour = s_hour; m_min = s_min;
            end else if (btn_inc) begin
                if (SNZ && Alarm && alon) begin
                    int t;
                    for (int i = 0; i < LD_HOLD; i++) q.push_back('{K_STOP, m_hour, m_min});
                    t = (s_hour * 60 + s_min + SNOOZE_MIN) % 1440;
                    s_hour = t / 60; s_min = t % 60;
                    for (int i = 0; i < LD_HOLD; i++) q.push_back('{K_ALARM, s_hour, s_min});
                end else begin
                    alon = !alon;
                end
            end
        end else begin
            if (btn_stop) begin
                mode = 0;
            end else if (btn_mode) begin
                quiet = 0;
                if (mode == 1) mode = 2;
                else begin
                    mode = 0;
                    if (tgt_alarm) begin s_hour = m_hour; s_min = m_min; end
                    for (int i = 0; i < LD_HOLD; i++)
                        q.push_back('{tgt_alarm ? K_ALARM : K_TIME, m_hour, m_min});
                end
            end else if (btn_inc && !btn_set) begin
                quiet = 0;
                if (mode == 1) m_hour = (m_hour + 1) % 24;
                else           m_min  = (m_min + 1) % 60;
            end else begin
                quiet++;
                if (quiet >= TIMEOUT_CYC) mode = 0;
            end
        end
    end

    function automatic int exp_kind();
        return (q.size() != 0) ? q[0].kind : K_NONE;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("edit_st",  int'(edit_st),  (q.size() != 0) ? 3 : mode);
            check("H_in1",    int'(H_in1),    m_hour / 10);
            check("H_in0",    int'(H_in0),    m_hour % 10);
            check("M_in1",    int'(M_in1),    m_min / 10);
            check("M_in0",    int'(M_in0),    m_min % 10);
            check("LD_time",  int'(LD_time),  int'(exp_kind() == K_TIME));
            check("LD_alarm", int'(LD_alarm), int'(exp_kind() == K_ALARM));
            check("STOP_al",  int'(STOP_al),  int'(exp_kind() == K_STOP));
            check("AL_ON",    int'(AL_ON),    int'(alon));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; the buttons are seen by exactly one rising edge.
    task automatic press(input bit st, input bit md, input bit se, input bit inc);
        btn_stop = st; btn_mode = md; btn_set = se; btn_inc = inc;
        @(negedge clk);
        btn_stop = 0; btn_mode = 0; btn_set = 0; btn_inc = 0;
    endtask

    task automatic press_n(input bit st, input bit md, input bit se, input bit inc, input int n);
        for (int i = 0; i < n; i++) press(st, md, se, inc);
    endtask

    task automatic count_strobes(input int n, output int nt, output int na, output int ns);
        nt = 0; na = 0; ns = 0;
        for (int i = 0; i < n; i++) begin
            nt += int'(LD_time); na += int'(LD_alarm); ns += int'(STOP_al);
            @(negedge clk);
        end
    endtask

    task automatic check_hm(input string name, input int h, input int m);
        check({name, "_h1"}, int'(H_in1), h / 10);
        check({name, "_h0"}, int'(H_in0), h % 10);
        check({name, "_m1"}, int'(M_in1), m / 10);
        check({name, "_m0"}, int'(M_in0), m % 10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nt, na, ns;
        reset = 0; btn_mode = 0; btn_set = 0; btn_inc = 0; btn_stop = 0; Alarm = 0;
        H_out1 = 2'd1; H_out0 = 4'd1; M_out1 = 4'd2; M_out0 = 4'd6;   // 11:26
        tick(2);
        check("rst_edit_st", int'(edit_st), 0);
        check_hm("rst", 0, 0);
        check("rst_strobes", int'(LD_time) + int'(LD_alarm) + int'(STOP_al), 0);
        check("rst_al_on", int'(AL_ON), 0);
        #2 reset = 1;
        @(negedge clk);
        cmp_en = 1;

        // Reset in the middle of an alarm load wipes the shadow back to 00:00.
        press(0, 0, 1, 0);            // set
        press(0, 0, 0, 1);            // hour 01
        press(0, 1, 0, 0);            // -> MIN
        press(0, 1, 0, 0);            // commit alarm 01:00
        check("t1_ld_alarm", int'(LD_alarm), 1);
        tick(3);
        #2 reset = 0;
        @(negedge clk);
        check("t1_edit_st", int'(edit_st), 0);
        check("t1_ld_alarm_rst", int'(LD_alarm), 0);
        check_hm("t1_rst", 0, 0);
        #2 reset = 1;
        @(negedge clk);
        press(0, 0, 1, 0);            // set preloads the shadow
        check_hm("t1_shadow", 0, 0);
        press(1, 0, 0, 0);            // cancel

        // Time edit 11:26 -> 13:30.
        press(0, 1, 0, 0);
        check_hm("t2_preload", 11, 26);
        press_n(0, 0, 0, 1, 2);
        press(0, 1, 0, 0);
        press_n(0, 0, 0, 1, 4);
        press(0, 1, 0, 0);            // commit
        check_hm("t2_load", 13, 30);
        check("t2_edit_st", int'(edit_st), 3);
        count_strobes(LD_HOLD + 2, nt, na, ns);
        check("t2_ld_time_cycles", nt, 10);
        check("t2_other_strobes", na + ns, 0);

        // Alarm edit: hour wrap, then minute wrap without carry.
        press(0, 0, 1, 0);
        press_n(0, 0, 0, 1, 23);
        check_hm("t3_h23", 23, 0);
        press(0, 0, 0, 1);
        check_hm("t3_hwrap", 0, 0);
        press_n(0, 0, 0, 1, 5);
        press(0, 1, 0, 0);
        press_n(0, 0, 0, 1, 59);
        check_hm("t3_m59", 5, 59);
        press(0, 0, 0, 1);
        check_hm("t3_mwrap", 5, 0);
        press(0, 1, 0, 0);            // commit alarm 05:00
        count_strobes(LD_HOLD + 2, nt, na, ns);
        check("t3_ld_alarm_cycles", na, 10);
        check("t3_other_strobes", nt + ns, 0);

        // Timeout abandons the edit; mode outranks a coincident inc.
        press(0, 1, 0, 1);
        check("t4_al_on_kept", int'(AL_ON), 0);
        tick(TIMEOUT_CYC - 1);
        check("t4_still_hr", int'(edit_st), 1);
        tick(1);
        check("t4_timeout_idle", int'(edit_st), 0);
        count_strobes(5, nt, na, ns);
        check("t4_timeout_no_strobe", nt + na + ns, 0);
        press(0, 0, 1, 0);
        check_hm("t4_shadow_kept", 5, 0);
        press(0, 1, 0, 0);
        press_n(0, 0, 0, 1, 3);
        press(1, 0, 0, 0);            // cancel in MIN
        check("t4_cancel_idle", int'(edit_st), 0);
        count_strobes(3, nt, na, ns);
        check("t4_cancel_no_strobe", nt + na + ns, 0);
        press(0, 0, 1, 0);
        check_hm("t4_shadow_after_cancel", 5, 0);
        press(1, 0, 0, 0);

        // Stop outranks inc while ringing; AL_ON untouched.
        press(0, 0, 0, 1);
        check("t5_al_on_toggle", int'(AL_ON), 1);
        press(1, 0, 0, 0);            // stop with no alarm ringing is ignored
        check("t5_stop_ignored", int'(edit_st), 0);
        Alarm = 1;
        press(1, 0, 0, 1);
        count_strobes(LD_HOLD + 2, nt, na, ns);
        check("t5_stop_cycles", ns, 10);
        check("t5_other_strobes", nt + na, 0);
        check("t5_al_on_kept", int'(AL_ON), 1);
        Alarm = 0;

        // Alarm 23:58 then inc while ringing with AL_ON=1.
        press(0, 0, 1, 0);
        press_n(0, 0, 0, 1, 18);
        press(0, 1, 0, 0);
        press_n(0, 0, 0, 1, 58);
        check_hm("t6_setup", 23, 58);
        press(0, 1, 0, 0);
        tick(LD_HOLD + 2);
        Alarm = 1;
        press(0, 0, 0, 1);
`ifdef ACLOCK_SNOOZE_EN
        count_strobes(LD_HOLD, nt, na, ns);
        check("t6_snz_stop_cycles", ns, 10);
        check("t6_snz_no_load_yet", nt + na, 0);
        check_hm("t6_snz_value", 0, 3);
        count_strobes(LD_HOLD + 2, nt, na, ns);
        check("t6_snz_ld_alarm_cycles", na, 10);
        check("t6_snz_other", nt + ns, 0);
        check("t6_al_on", int'(AL_ON), 1);
`else
        check("t6_al_on_off", int'(AL_ON), 0);
        count_strobes(LD_HOLD + 2, nt, na, ns);
        check("t6_no_strobe", nt + na + ns, 0);
        check("t6_idle", int'(edit_st), 0);
`endif
        Alarm = 0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
